// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: owns the PC, fetches from a combinational imem and holds the word in the IF/ID register
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc_plus4,
  output logic        misalign_err,
  output logic [31:0] fetch_count
);
  logic [31:0] r_pc, r_instr, r_out_pc, r_count;
  logic        r_valid, r_mis;
  logic        w_load;
  assign w_load       = run && (!r_valid || out_ready);
  assign imem_addr    = r_pc;
  assign out_valid    = r_valid;
  assign out_instr    = r_instr;
  assign out_pc       = r_out_pc;
  assign out_pc_plus4 = r_out_pc + 32'd4;
  assign misalign_err = r_mis;
  assign fetch_count  = r_count;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc     <= RESET_PC;
      r_valid  <= 1'b0;
      r_instr  <= '0;
      r_out_pc <= '0;
      r_count  <= '0;
      r_mis    <= 1'b0;
    end else begin
      r_mis <= 1'b0;
      // a handshake on a redirect edge still counts: decode took the word first
      if (r_valid && out_ready) r_count <= r_count + 32'd1;
      if (redirect_valid) begin
        r_pc    <= {redirect_pc[31:2], 2'b00};
        r_valid <= 1'b0;
        r_mis   <= |redirect_pc[1:0];
      end else if (w_load) begin
        r_instr  <= imem_instr;
        r_out_pc <= r_pc;
        r_valid  <= 1'b1;
        r_pc     <= r_pc + 32'd4;
      end else if (out_ready) begin
        r_valid <= 1'b0;
      end
    end
  end
endmodule
